prize_spawn_scheduler: RTL

- Sequences the random-number source for the Bumpy prize system.
- Decides when a prize spawns, requests a random value over a req/valid handshake, and maps that value to a free grid cell.
- Places the prize in one of NUM_SLOTS prize slots and retires each slot on collection or lifetime expiry.
- Sits between the random source and the prize drawing/collision logic; frame-paced by startOfFrame.

---
 rtl/prize_pkg.sv | 10 +
 rtl/prize_slot.sv | 44 ++++
 rtl/prize_spawn_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/prize_pkg.sv
// prize_pkg: shared FSM states, grid geometry and cell type for the prize scheduler
package prize_pkg;
  localparam int COL_W = 4;
  localparam int ROW_W = 3;
  typedef enum logic [1:0] {IDLE, REQ, CHECK, PLACE} state_e;
  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } cell_t;
endpackage

// File: rtl/prize_slot.sv
// prize_slot: one prize slot (active flag, cell, lifetime countdown, collect/expire)
// Ports: clk/reset; enable_i/tick_i pace the lifetime; collect_i retires a live prize;
// load_i/cell_i place a new prize; active_o/cell_o show the slot; expire_o flags a timeout.
module prize_slot import prize_pkg::*; #(
  parameter int LIFETIME = 600,
  localparam int LW = $clog2(LIFETIME + 1)
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  enable_i,
  input  logic  tick_i,
  input  logic  collect_i,
  input  logic  load_i,
  input  cell_t cell_i,
  output logic  active_o,
  output cell_t cell_o,
  output logic  expire_o
);
  logic active_q;
  cell_t cell_q;
  logic [LW-1:0] life_q;
  logic tick_en;
  assign tick_en = enable_i & tick_i;
  // collect wins over a same-cycle timeout, so no expiry is reported then
  assign expire_o = active_q & tick_en & ~collect_i & (life_q == LW'(1));
  assign active_o = active_q;
  assign cell_o = cell_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cell_q <= '0;
      life_q <= '0;
    end else if (load_i) begin
      active_q <= 1'b1;
      cell_q <= cell_i;
      life_q <= LW'(LIFETIME);
    end else if ((collect_i & active_q) | expire_o) begin
      active_q <= 1'b0;
      life_q <= '0;
    end else if (active_q & tick_en) begin
      life_q <= life_q - 1'b1;
    end
  end
endmodule

// File: rtl/prize_spawn_scheduler.sv
// prize_spawn_scheduler: frame-paced prize spawning via a random source into NUM_SLOTS slots
// Ports: clk/reset; enable freezes timers and aborts a spawn; startOfFrame paces timers;
// rand_req/rand_valid/rand_value form the random handshake; collect retires slots;
// slot_active/slot_col/slot_row expose slots; spawn_pulse/expire_pulse mark placements/timeouts.
module prize_spawn_scheduler import prize_pkg::*; #(
  parameter int NUM_SLOTS = 4,
  parameter int RAND_W = 10,
  parameter int SPAWN_PERIOD = 120,
  parameter int LIFETIME = 600,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       startOfFrame,
  output logic                       rand_req,
  input  logic                       rand_valid,
  input  logic [RAND_W-1:0]          rand_value,
  input  logic [NUM_SLOTS-1:0]       collect,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [NUM_SLOTS*COL_W-1:0] slot_col,
  output logic [NUM_SLOTS*ROW_W-1:0] slot_row,
  output logic                       spawn_pulse,
  output logic                       expire_pulse
);
  localparam int TW = SPAWN_PERIOD > 1 ? $clog2(SPAWN_PERIOD) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic flag_q, flag_d;
  cell_t cell_q, cell_d;
  cell_t slot_cell [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit, expire, free, lowest, load;
  logic tick, wrap;
  logic unused_rand;
  assign unused_rand = ^rand_value[RAND_W-1:COL_W+ROW_W];
  genvar i;
  generate
    for (i = 0; i < NUM_SLOTS; i++) begin : g_slot
      prize_slot #(.LIFETIME(LIFETIME)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .tick_i    (startOfFrame),
        .collect_i (collect[i]),
        .load_i    (load[i]),
        .cell_i    (cell_q),
        .active_o  (slot_active[i]),
        .cell_o    (slot_cell[i]),
        .expire_o  (expire[i])
      );
      assign slot_col[i*COL_W +: COL_W] = slot_cell[i].col;
      assign slot_row[i*ROW_W +: ROW_W] = slot_cell[i].row;
      assign hit[i] = slot_active[i] && (slot_cell[i] == cell_q);
    end
  endgenerate
  // a slot collected this cycle counts as free, so a same-cycle placement may reuse it
  assign free = ~slot_active | collect;
  assign lowest = free & (~free + 1'b1);
  assign expire_pulse = |expire;
  assign tick = enable & startOfFrame;
  assign wrap = tick && (timer_q == TW'(SPAWN_PERIOD - 1));
  assign timer_d = wrap ? '0 : tick ? timer_q + 1'b1 : timer_q;
  assign rand_req = (state_q == REQ);
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cell_d = cell_q;
    flag_d = flag_q | wrap;
    load = '0;
    spawn_pulse = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: if (flag_q && !(&slot_active)) begin
          state_d = REQ;
          flag_d = wrap;
        end
        REQ: if (rand_valid) begin
          cell_d.col = rand_value[COL_W-1:0];
          cell_d.row = rand_value[COL_W+ROW_W-1:COL_W];
          state_d = CHECK;
        end
        CHECK: if (|hit) begin
          state_d = (retry_q == RW'(MAX_RETRY)) ? IDLE : REQ;
          retry_d = (retry_q == RW'(MAX_RETRY)) ? '0 : retry_q + 1'b1;
        end else begin
          state_d = PLACE;
        end
        PLACE: begin
          load = lowest;
          spawn_pulse = |lowest;
          retry_d = '0;
          state_d = IDLE;
        end
      endcase
    end
    if (&slot_active) flag_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      flag_q <= 1'b0;
      cell_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      flag_q <= flag_d;
      cell_q <= cell_d;
    end
  end
endmodule
